// File: rtl/lsu_dmem.sv
// RV64I load/store data memory: sized, extended loads, byte-lane merged stores,
// misalignment/range errors and a valid/ready handshake with LATENCY edges to response.
module lsu_dmem #(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_next;
  logic [1:0]      cnt;
  logic            accept;
  logic            cap_we, cap_unsigned;
  logic [1:0]      cap_size;
  logic [XLEN-1:0] cap_addr, cap_wdata;
  logic [XLEN-1:0] mem [DEPTH];
  logic            misaligned, out_of_range, acc_err;
  logic [IDXW-1:0] idx;
  logic [5:0]      bit_off;
  logic [XLEN-1:0] word, shifted, load_data, size_mask, lane_mask, merged;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept)
        cnt <= 2'(LATENCY - 1);
      else if (state == WAIT)
        cnt <= cnt - 2'd1;
    end
  end

  // RESP behaves like IDLE for acceptance so requests can issue back to back.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, RESP: state_next = accept ? ((LATENCY == 1) ? RESP : WAIT) : IDLE;
      WAIT:       if (cnt == 2'd1) state_next = RESP;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) || (state == RESP);
    busy      = (state == WAIT);
    rsp_valid = (state == RESP);
    rsp_err   = rsp_valid && acc_err;
    rsp_rdata = (rsp_valid && !acc_err && !cap_we) ? load_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      cap_we       <= req_we;
      cap_size     <= req_size;
      cap_unsigned <= req_unsigned;
      cap_addr     <= req_addr;
      cap_wdata    <= req_wdata;
    end
  end

  always_comb begin
    unique case (cap_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = cap_addr[0];
      2'd2:    misaligned = (cap_addr[1:0] != 2'd0);
      default: misaligned = (cap_addr[2:0] != 3'd0);
    endcase
    out_of_range = cap_addr[XLEN-1:3] >= (XLEN-3)'(DEPTH);
    acc_err      = misaligned || out_of_range;
  end

  assign idx     = cap_addr[3 +: IDXW];
  assign bit_off = {cap_addr[2:0], 3'b000};
  assign word    = mem[idx];
  assign shifted = word >> bit_off;

  always_comb begin
    unique case (cap_size)
      2'd0: load_data = cap_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                     : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'd1: load_data = cap_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                     : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      2'd2: load_data = cap_unsigned ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                     : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    unique case (cap_size)
      2'd0:    size_mask = {{(XLEN-8){1'b0}}, 8'hFF};
      2'd1:    size_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
      2'd2:    size_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
      default: size_mask = '1;
    endcase
    lane_mask = size_mask << bit_off;
    merged    = (word & ~lane_mask) | ((cap_wdata << bit_off) & lane_mask);
  end

  // Stores commit on the edge that closes RESP, so a load accepted in RESP sees them.
  always_ff @(posedge clk) begin
    if (rst_n && (state == RESP) && cap_we && !acc_err)
      mem[idx] <= merged;
  end

endmodule

// File: tb/tb_lsu_dmem.sv
// Scoreboard bench for lsu_dmem: two instances (LATENCY 1 and 3) driven by directed
// and random requests, checked against a byte-addressed reference memory.
module tb_lsu_dmem;

  localparam int DEPTH = 1024;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0]            req_valid, req_we, req_unsigned;
  logic [1:0][1:0]       req_size;
  logic [1:0][63:0]      req_addr, req_wdata;
  wire  [1:0]            req_ready, rsp_valid, rsp_err, busy;
  wire  [1:0][63:0]      rsp_rdata;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] refm [2][DEPTH*8];

  lsu_dmem #(.XLEN(64), .DEPTH(DEPTH), .LATENCY(1)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  lsu_dmem #(.XLEN(64), .DEPTH(DEPTH), .LATENCY(3)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Byte-addressed reference: accesses are lists of bytes, extension by plain arithmetic.
  task automatic refModel(input int inst, input bit we, input bit [1:0] size, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          output logic err, output logic [63:0] rdata);
    int n;
    n     = 1 << size;
    rdata = '0;
    err   = ((addr % 64'(n)) != 64'd0) || (addr >= 64'(DEPTH * 8));
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        if (we) refm[inst][int'(addr) + i] = wdata[8*i +: 8];
        else    rdata[8*i +: 8] = refm[inst][int'(addr) + i];
      end
      if (!we && !uns && n < 8 && rdata[8*n-1] === 1'b1)
        for (int i = n; i < 8; i++) rdata[8*i +: 8] = 8'hFF;
    end
  endtask

  task automatic applyStimulus(input int inst, input bit we, input bit [1:0] size, input bit uns,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input bit track, output int acc_cyc);
    int   w;
    exp_t e;
    @(negedge clk);
    req_valid[inst]    = 1'b1;
    req_we[inst]       = we;
    req_size[inst]     = size;
    req_unsigned[inst] = uns;
    req_addr[inst]     = addr;
    req_wdata[inst]    = wdata;
    w = 0;
    while (req_ready[inst] !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout dut%0d: got req_ready=%b, required 1", inst, req_ready[inst]);
      req_valid[inst] = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc + 1;
    if (track) begin
      refModel(inst, we, size, uns, addr, wdata, e.err, e.rdata);
      e.cyc = cyc + ((inst == 0) ? 1 : 3);
      if (inst == 0) q0.push_back(e);
      else           q1.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid[inst]    = 1'b0;
    req_we[inst]       = 1'($urandom);
    req_size[inst]     = 2'($urandom);
    req_unsigned[inst] = 1'($urandom);
    req_addr[inst]     = {$urandom, $urandom};
    req_wdata[inst]    = {$urandom, $urandom};
  endtask

  task automatic monitorInst(input int inst);
    exp_t e;
    bit   have;
    have = (inst == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (have) begin
      if (inst == 0) e = q0[0];
      else           e = q1[0];
    end
    if (rsp_valid[inst] === 1'b1) begin
      if (!have) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_rsp dut%0d: got rsp_valid=1 at cycle %0d, required no response", inst, cyc);
      end else begin
        if (inst == 0) q0.delete(0);
        else           q1.delete(0);
        checkOutput($sformatf("dut%0d rsp_err", inst), 64'(rsp_err[inst]), 64'(e.err));
        checkOutput($sformatf("dut%0d rsp_rdata", inst), rsp_rdata[inst], e.rdata);
        checkOutput($sformatf("dut%0d rsp_cycle", inst), 64'(cyc), 64'(e.cyc));
      end
    end else begin
      checkOutput($sformatf("dut%0d idle_valid", inst), 64'(rsp_valid[inst]), 64'd0);
      checkOutput($sformatf("dut%0d idle_rdata", inst), rsp_rdata[inst], 64'd0);
      checkOutput($sformatf("dut%0d idle_err", inst), 64'(rsp_err[inst]), 64'd0);
      if (have && e.cyc <= cyc) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL missing_rsp dut%0d: got no rsp_valid at cycle %0d, required one at cycle %0d", inst, cyc, e.cyc);
        if (inst == 0) q0.delete(0);
        else           q1.delete(0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitorInst(0);
      monitorInst(1);
    end
  end

  task automatic randomOps(input int inst, input int n);
    int          a;
    int          r;
    logic [63:0] addr;
    for (int i = 0; i < 32; i++)
      applyStimulus(inst, 1'b1, 2'd3, 1'b0, 64'h100 + 64'(8*i), {$urandom, $urandom}, 1'b1, a);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = 64'(DEPTH * 8) + 64'($urandom_range(0, 255));
      else if (r == 1) addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      else             addr = 64'h100 + 64'($urandom_range(0, 255));
      applyStimulus(inst, 1'($urandom), 2'($urandom), 1'($urandom), addr, {$urandom, $urandom}, 1'b1, a);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion, required $finish before time limit");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int a1, a2, w;
    rst_n        = 1'b0;
    req_valid    = 2'b11;
    req_we       = 2'b11;
    req_size     = '0;
    req_unsigned = '0;
    req_addr     = '0;
    req_wdata    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b00;
    mon_en    = 1'b1;
    checkOutput("rst_ready0", 64'(req_ready[0]), 64'd1);
    checkOutput("rst_ready1", 64'(req_ready[1]), 64'd1);
    checkOutput("rst_busy1", 64'(busy[1]), 64'd0);
    repeat (4) @(negedge clk);

    applyStimulus(0, 1'b1, 2'd3, 1'b0, 64'h10, 64'h1122_3344_5566_7788, 1'b1, a1);
    applyStimulus(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 1'b1, a2);
    checkOutput("b2b_accept", 64'(a2), 64'(a1 + 1));
    applyStimulus(0, 1'b1, 2'd0, 1'b0, 64'h13, 64'hF0, 1'b1, a1);
    applyStimulus(0, 1'b0, 2'd0, 1'b0, 64'h13, 64'h0, 1'b1, a1);
    applyStimulus(0, 1'b0, 2'd0, 1'b1, 64'h13, 64'h0, 1'b1, a1);
    applyStimulus(0, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 1'b1, a1);
    applyStimulus(0, 1'b1, 2'd3, 1'b0, 64'h20, 64'h0, 1'b1, a1);
    applyStimulus(0, 1'b1, 2'd2, 1'b0, 64'h20, 64'h8000_0001, 1'b1, a1);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 64'h20, 64'h0, 1'b1, a1);
    applyStimulus(0, 1'b0, 2'd2, 1'b1, 64'h20, 64'h0, 1'b1, a1);
    applyStimulus(0, 1'b0, 2'd1, 1'b0, 64'h22, 64'h0, 1'b1, a1);
    applyStimulus(0, 1'b0, 2'd2, 1'b0, 64'h22, 64'h0, 1'b1, a1);
    applyStimulus(0, 1'b1, 2'd2, 1'b0, 64'h22, 64'hDEAD_BEEF, 1'b1, a1);
    applyStimulus(0, 1'b1, 2'd3, 1'b0, 64'(DEPTH * 8), 64'h55, 1'b1, a1);
    applyStimulus(0, 1'b0, 2'd3, 1'b0, 64'h20, 64'h0, 1'b1, a1);

    applyStimulus(1, 1'b1, 2'd3, 1'b0, 64'h40, 64'hAA, 1'b1, a1);
    @(negedge clk);
    checkOutput("lat3_busy_c1", 64'(busy[1]), 64'd1);
    checkOutput("lat3_ready_c1", 64'(req_ready[1]), 64'd0);
    @(negedge clk);
    checkOutput("lat3_busy_c2", 64'(busy[1]), 64'd1);
    checkOutput("lat3_ready_c2", 64'(req_ready[1]), 64'd0);
    @(negedge clk);
    checkOutput("lat3_busy_c3", 64'(busy[1]), 64'd0);
    checkOutput("lat3_ready_c3", 64'(req_ready[1]), 64'd1);
    applyStimulus(1, 1'b1, 2'd3, 1'b0, 64'h40, 64'hBB, 1'b0, a1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_busy", 64'(busy[1]), 64'd0);
    checkOutput("midrst_ready", 64'(req_ready[1]), 64'd1);
    repeat (4) @(negedge clk);
    applyStimulus(1, 1'b0, 2'd3, 1'b0, 64'h40, 64'h0, 1'b1, a1);

    randomOps(0, 150);
    randomOps(1, 150);

    w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d/%0d pending, required 0/0", q0.size(), q1.size());
    end
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
